// File: rtl/game_pkg.sv
// Shared encodings for the game link: local game FSM states and the
// message header bytes sent to the peer board.
package game_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_WAIT  = 2'd1,
    GS_GAME  = 2'd2,
    GS_SCORE = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    MSG_READY = 2'd0,
    MSG_STOP  = 2'd1,
    MSG_SCORE = 2'd2
  } msg_kind_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_LOAD = 2'd1,
    MS_SEND = 2'd2,
    MS_NEXT = 2'd3
  } msg_state_e;

  localparam logic [7:0] HDR_READY = 8'hA5;
  localparam logic [7:0] HDR_STOP  = 8'h5A;
  localparam logic [7:0] HDR_SCORE = 8'hC3;

  function automatic logic [7:0] msg_header(input msg_kind_e kind);
    case (kind)
      MSG_STOP:  msg_header = HDR_STOP;
      MSG_SCORE: msg_header = HDR_SCORE;
      default:   msg_header = HDR_READY;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start 0, data LSB first, stop 1, each CLKS_PER_BIT
// cycles. done marks the last stop-bit cycle so a new start can follow with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_q, active_d;
  logic          tx_q, tx_d;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_end;

  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    bit_end  = active_q && (cnt_q == CW'(CLKS_PER_BIT - 1));
    done     = bit_end && (bit_q == 4'd9);
    if (active_q) begin
      cnt_d = cnt_q + 1'b1;
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          // sh_q holds {stop, data}; bit k of the frame leaves from sh_q[0]
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end
    end
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      sh_d     = {1'b1, data};
      bit_d    = 4'd0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      sh_q     <= '1;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/game_link_tx.sv
// Sends READY/STOP/SCORE messages to the peer board on game state changes.
// Define GAME_LINK_CHECKSUM_EN to append an XOR checksum byte to every message.
module game_link_tx
  import game_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 564,
  parameter int HEARTBEAT_CYC = 6500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] game_state,
  input  logic [7:0] score,
  output logic       tx,
  output logic       busy
);

  localparam int HW = $clog2(HEARTBEAT_CYC + 1);
`ifdef GAME_LINK_CHECKSUM_EN
  localparam logic [1:0] EXTRA = 2'd1;
`else
  localparam logic [1:0] EXTRA = 2'd0;
`endif

  game_state_e   gs_in, gs_q, gs_d;
  logic          gs_vld_q, gs_vld_d;
  logic          evt;
  logic          ready_q, ready_d, stop_q, stop_d, spend_q, spend_d;
  logic [7:0]    score_lat_q, score_lat_d, score_msg_q, score_msg_d;
  logic [HW-1:0] hb_q, hb_d;
  msg_state_e    ms_q, ms_d;
  msg_kind_e     sel_q, sel_d;
  logic [1:0]    idx_q, idx_d, len, byte_idx;
  logic          ser_start, ser_done;
  logic [7:0]    ser_data, hdr;

  // Event detection and pending flags
  always_comb begin
    gs_in       = game_state_e'(game_state);
    gs_d        = gs_in;
    gs_vld_d    = 1'b1;
    evt         = gs_vld_q && (gs_q != gs_in);
    ready_d     = ready_q;
    stop_d      = stop_q;
    spend_d     = spend_q;
    score_lat_d = score_lat_q;
    hb_d        = hb_q;
    if (ms_q == MS_LOAD) begin
      case (sel_q)
        MSG_STOP:  stop_d  = 1'b0;
        MSG_SCORE: spend_d = 1'b0;
        default:   ready_d = 1'b0;
      endcase
    end
    if (evt && gs_q == GS_WAIT) begin
      ready_d = 1'b0;
      hb_d    = '0;
    end
    if (evt && gs_in == GS_WAIT) begin
      ready_d = 1'b1;
      hb_d    = '0;
    end else if (!evt && gs_vld_q && gs_q == GS_WAIT) begin
      if (hb_q == HW'(HEARTBEAT_CYC - 1)) begin
        ready_d = 1'b1;
        hb_d    = '0;
      end else begin
        hb_d = hb_q + 1'b1;
      end
    end
    if (evt && gs_q == GS_GAME && gs_in == GS_IDLE) stop_d = 1'b1;
    if (evt && gs_in == GS_SCORE) begin
      spend_d     = 1'b1;
      score_lat_d = score;
    end
  end

  // Message sequencer
  always_comb begin
    ms_d        = ms_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    score_msg_d = score_msg_q;
    ser_start   = 1'b0;
    byte_idx    = idx_q + 2'd1;
    len         = ((sel_q == MSG_SCORE) ? 2'd2 : 2'd1) + EXTRA;
    case (ms_q)
      MS_IDLE: begin
        if (stop_q) begin
          sel_d = MSG_STOP;
          ms_d  = MS_LOAD;
        end else if (spend_q) begin
          sel_d = MSG_SCORE;
          ms_d  = MS_LOAD;
        end else if (ready_q) begin
          sel_d = MSG_READY;
          ms_d  = MS_LOAD;
        end
      end
      MS_LOAD: begin
        ser_start   = 1'b1;
        byte_idx    = 2'd0;
        idx_d       = 2'd0;
        score_msg_d = score_lat_q;
        ms_d        = MS_SEND;
      end
      MS_SEND: begin
        if (ser_done) begin
          if (idx_q == len - 2'd1) begin
            ms_d = MS_IDLE;
          end else begin
            ser_start = 1'b1;
            idx_d     = idx_q + 2'd1;
            ms_d      = MS_NEXT;
          end
        end
      end
      MS_NEXT: ms_d = MS_SEND;
      default: ms_d = MS_IDLE;
    endcase
  end

  // Byte 1 of a one-byte message is its checksum, which equals the header
  always_comb begin
    hdr = msg_header(sel_q);
    case (byte_idx)
      2'd0:    ser_data = hdr;
      2'd1:    ser_data = (sel_q == MSG_SCORE) ? score_msg_q : hdr;
      default: ser_data = hdr ^ score_msg_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gs_q        <= GS_IDLE;
      gs_vld_q    <= 1'b0;
      ready_q     <= 1'b0;
      stop_q      <= 1'b0;
      spend_q     <= 1'b0;
      score_lat_q <= 8'h00;
      score_msg_q <= 8'h00;
      hb_q        <= '0;
      ms_q        <= MS_IDLE;
      sel_q       <= MSG_READY;
      idx_q       <= 2'd0;
    end else begin
      gs_q        <= gs_d;
      gs_vld_q    <= gs_vld_d;
      ready_q     <= ready_d;
      stop_q      <= stop_d;
      spend_q     <= spend_d;
      score_lat_q <= score_lat_d;
      score_msg_q <= score_msg_d;
      hb_q        <= hb_d;
      ms_q        <= ms_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
    end
  end

  assign busy = ready_q || stop_q || spend_q || (ms_q != MS_IDLE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (ser_start),
    .data   (ser_data),
    .tx     (tx),
    .done   (ser_done)
  );

endmodule

// File: doc/game_link_tx.md
GAME_LINK_TX -- requirements
Module: game_link_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 564, clk cycles per UART bit (65 MHz / 115200).
REQ-002 SHALL have parameter HEARTBEAT_CYC, default 6500000, cycles between READY repeats (100 ms).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port game_state  input  2  local game FSM state: 0 IDLE, 1 WAIT, 2 GAME, 3 SCORE.
REQ-006 SHALL have port score  input  8  local score, sampled on entry to SCORE.
REQ-007 SHALL have port tx  output  1  UART 8N1 serial line to peer board, idle high.
REQ-008 SHALL have port busy  output  1  high while any frame bit is on the line or any message is pending.

Function
REQ-009 SHALL register game_state every cycle and detect a transition when the registered value differs from the input.
REQ-010 SHALL set pending READY on transition into WAIT; while game_state stays WAIT, SHALL re-set pending READY every HEARTBEAT_CYC cycles.
REQ-011 SHALL set pending STOP on a transition GAME->IDLE.
REQ-012 SHALL set pending SCORE and latch score on a transition into SCORE.
REQ-013 SHALL clear pending READY and the heartbeat counter when game_state leaves WAIT.
REQ-014 Message bytes: READY = 0xA5; STOP = 0x5A; SCORE = 0xC3 followed by the latched score byte.
REQ-015 Message FSM states: IDLE, LOAD, SEND, NEXT. It SHALL select the highest pending message (STOP > SCORE > READY) in IDLE, clearing that flag in LOAD.
REQ-016 A started message SHALL always complete. Flags set during transmission remain pending; a repeat set of an already-pending flag SHALL be merged.
REQ-017 Byte serializer SHALL send start bit 0, 8 data bits LSB first, stop bit 1, each held exactly CLKS_PER_BIT cycles.
REQ-018 Consecutive bytes of one message SHALL be back-to-back, with no idle gap after the stop bit.
REQ-019 Latency: first start bit SHALL appear on tx no later than 3 cycles after the transition that set the flag, if the line is idle.
REQ-020 A SCORE message SHALL transmit the value latched at entry, even if score changes mid-frame.
REQ-021 Simultaneous STOP and READY pending: STOP SHALL go first, then READY.

Reset
REQ-022 reset_n low SHALL asynchronously force: tx=1, busy=0, all pending flags=0, FSMs=IDLE, counters=0, registered game_state=IDLE.
REQ-023 Reset mid-frame SHALL abort the byte immediately (tx=1). No partial message SHALL resume after release.
REQ-024 After release, the first game_state sample SHALL NOT generate a transition event.

Configuration
REQ-025 Macro GAME_LINK_CHECKSUM_EN defined: each message SHALL append one byte equal to the XOR of all its preceding bytes (READY -> 0xA5, SCORE 0x12 -> 0xD1).
REQ-026 Macro undefined: no checksum byte; messages are exactly as in REQ-014.

Structure
REQ-027 Shared package game_pkg SHALL hold the game state encodings (IDLE/WAIT/GAME/SCORE) and message byte constants (READY/STOP/SCORE header).
REQ-028 The serializer SHALL be sub-module uart_tx_byte (ports: clk, reset_n, start, data[7:0], tx, done). game_link_tx owns message sequencing.

Verification (bench uses CLKS_PER_BIT=4, HEARTBEAT_CYC=200)
REQ-029 IDLE->WAIT -> tx carries 0xA5 (bits 0,1,0,1,0,0,1,0,1,1 at 4-cycle spacing); a second 0xA5 frame starts 200 cycles after the first flag set.
REQ-030 WAIT->GAME->SCORE with score=0x12, score changed to 0x34 mid-frame -> tx carries 0xC3 then 0x12 back-to-back; busy high for 80 cycles.
REQ-031 GAME->IDLE while a READY frame is on the line -> READY completes, then 0x5A follows. No READY repeat occurs because state left WAIT.
REQ-032 reset_n low at bit 5 of a SCORE frame -> tx=1 and busy=0 within the same cycle; after release, tx stays high with game_state held constant.
REQ-033 With GAME_LINK_CHECKSUM_EN, SCORE=0x12 -> bytes 0xC3, 0x12, 0xD1; without it, only 0xC3, 0x12.
